// File: rtl/bcd_pkg.sv
// Shared constants and helpers for the packed-BCD adder.
package bcd_pkg;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;

  // True when the nibble is a legal decimal digit (0..9).
  function automatic logic is_bcd(input logic [3:0] d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One decimal digit of the ripple adder: binary add, then +6 correction on overflow.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] a_d,
  input  logic [3:0] b_d,
  input  logic       c_in,
  output logic [3:0] s_d,
  output logic       c_out,
  output logic       bad
);

  logic [4:0] t;
  logic [3:0] t_corr;

  // Raw 5-bit digit sum. Out-of-range digits use the same correction rule, so the
  // result stays defined and only the bad flag tells them apart.
  always_comb begin
    t      = {1'b0, a_d} + {1'b0, b_d} + {4'b0, c_in};
    // Only the low nibble of t+6 is kept, so adding to t[3:0] gives the same bits.
    t_corr = t[3:0] + BCD_CORR;
    c_out  = (t > {1'b0, BCD_MAX});
    s_d    = c_out ? t_corr : t[3:0];
    bad    = !is_bcd(a_d) || !is_bcd(b_d);
  end

endmodule

// File: rtl/bcd_adder.sv
// Registered packed-BCD adder: ripple-carry digits, one output register stage.
module bcd_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  input  logic                  in_valid,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  out_valid,
  output logic                  err
);

  logic [DIGITS:0]       carry;
  logic [DIGITS-1:0]     bad;
  logic [4*DIGITS-1:0]   sum_d, sum_q;
  logic                  cout_d, cout_q;
  logic                  err_d, err_q;
  logic                  vld_q;

  assign carry[0] = cin;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcd_digit_add u_dig (
      .a_d   (a[4*i +: 4]),
      .b_d   (b[4*i +: 4]),
      .c_in  (carry[i]),
      .s_d   (sum_d[4*i +: 4]),
      .c_out (carry[i+1]),
      .bad   (bad[i])
    );
  end

  assign cout_d = carry[DIGITS];
  assign err_d  = |bad;

  // Capture a new result on accepted operands; otherwise hold data and drop valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      err_q  <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= in_valid;
      if (in_valid) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        err_q  <= err_d;
      end
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign err       = err_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_bcd_adder.sv
// Directed bench for bcd_adder at DIGITS=1 and DIGITS=2 with a result scoreboard.
module tb_bcd_adder;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a1 = '0, b1 = '0;
  logic       cin1 = 1'b0, iv1 = 1'b0;
  logic [3:0] sum1;
  logic       cout1, ov1, err1;
  logic [7:0] a2 = '0, b2 = '0;
  logic       cin2 = 1'b0, iv2 = 1'b0;
  logic [7:0] sum2;
  logic       cout2, ov2, err2;

  int   checks   = 0;
  int   failures = 0;
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  bcd_adder #(.DIGITS(1)) dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(cin1), .in_valid(iv1),
    .sum(sum1), .cout(cout1), .out_valid(ov1), .err(err1)
  );

  bcd_adder #(.DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .a(a2), .b(b2), .cin(cin2), .in_valid(iv2),
    .sum(sum2), .cout(cout2), .out_valid(ov2), .err(err2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one DIGITS=1 transaction, push its expectation, compare after the edge.
  task automatic step1_exp(input logic [3:0] a, input logic [3:0] b, input logic c,
                           input logic [3:0] es, input logic ec, input logic ee);
    exp_t e, got;
    a1 = a; b1 = b; cin1 = c; iv1 = 1'b1;
    e.sum = {4'h0, es}; e.cout = ec; e.err = ee;
    q1.push_back(e);
    @(posedge clk); #1;
    chk("q1_nonempty", 32'(q1.size() != 0), 32'd1);
    if (q1.size() != 0) begin
      got = q1.pop_front();
      chk("d1_sum",  32'(sum1),  32'(got.sum[3:0]));
      chk("d1_cout", 32'(cout1), 32'(got.cout));
      chk("d1_err",  32'(err1),  32'(got.err));
      chk("d1_ov",   32'(ov1),   32'd1);
    end
  endtask

  // Decimal-value model for legal digits.
  task automatic step1(input int a, input int b, input int c);
    int t;
    t = a + b + c;
    step1_exp(4'(a), 4'(b), c[0], 4'(t % 10), (t >= 10), 1'b0);
  endtask

  task automatic step2_exp(input logic [7:0] a, input logic [7:0] b, input logic c,
                           input logic [7:0] es, input logic ec, input logic ee);
    exp_t e, got;
    a2 = a; b2 = b; cin2 = c; iv2 = 1'b1;
    e.sum = es; e.cout = ec; e.err = ee;
    q2.push_back(e);
    @(posedge clk); #1;
    chk("q2_nonempty", 32'(q2.size() != 0), 32'd1);
    if (q2.size() != 0) begin
      got = q2.pop_front();
      chk("d2_sum",  32'(sum2),  32'(got.sum));
      chk("d2_cout", 32'(cout2), 32'(got.cout));
      chk("d2_err",  32'(err2),  32'(got.err));
      chk("d2_ov",   32'(ov2),   32'd1);
    end
  endtask

  task automatic step2(input int a, input int b, input int c);
    int t, r;
    t = a + b + c;
    r = t % 100;
    step2_exp({4'(a / 10), 4'(a % 10)}, {4'(b / 10), 4'(b % 10)}, c[0],
              {4'(r / 10), 4'(r % 10)}, (t >= 100), 1'b0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sum1", 32'(sum1), 32'd0);
    chk("rst_cout1", 32'(cout1), 32'd0);
    chk("rst_ov1", 32'(ov1), 32'd0);
    chk("rst_err1", 32'(err1), 32'd0);
    chk("rst_sum2", 32'(sum2), 32'd0);
    chk("rst_ov2", 32'(ov2), 32'd0);
    rst = 1'b0;

    // Basic single-digit cases, back-to-back
    step1(5, 4, 0);
    step1(5, 5, 0);
    step1(9, 9, 1);

    // Exhaustive legal single-digit space
    for (int a = 0; a < 10; a++)
      for (int b = 0; b < 10; b++)
        for (int c = 0; c < 2; c++)
          step1(a, b, c);

    // Illegal digits keep the correction rule and raise err
    step1_exp(4'hC, 4'h3, 1'b0, 4'h5, 1'b1, 1'b1);
    step1_exp(4'hF, 4'hF, 1'b1, 4'h5, 1'b1, 1'b1);
    step1(2, 3, 0);
    iv1 = 1'b0;

    // Two-digit ripple
    step2(99, 1, 0);
    step2(47, 38, 1);
    step2(99, 99, 1);
    step2(50, 49, 1);
    step2_exp(8'h0A, 8'h00, 1'b0, 8'h10, 1'b0, 1'b1);
    step2(12, 34, 0);
    iv2 = 1'b0;

    // Idle: data holds, valid drops
    @(posedge clk); #1;
    chk("idle_ov1", 32'(ov1), 32'd0);
    chk("idle_sum1", 32'(sum1), 32'h5);
    chk("idle_ov2", 32'(ov2), 32'd0);
    chk("idle_sum2", 32'(sum2), 32'h46);

    // Reset wins over in_valid
    a1 = 4'h9; b1 = 4'h9; cin1 = 1'b0; iv1 = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstv_sum1", 32'(sum1), 32'd0);
    chk("rstv_cout1", 32'(cout1), 32'd0);
    chk("rstv_ov1", 32'(ov1), 32'd0);
    chk("rstv_err1", 32'(err1), 32'd0);
    rst = 1'b0; iv1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("hold_sum1", 32'(sum1), 32'd0);
    chk("hold_cout1", 32'(cout1), 32'd0);
    chk("hold_ov1", 32'(ov1), 32'd0);

    // First transaction after reset is normal
    step1(9, 9, 0);
    iv1 = 1'b0;
    @(posedge clk); #1;
    chk("final_ov1", 32'(ov1), 32'd0);
    chk("final_sum1", 32'(sum1), 32'h8);
    chk("q_drained", 32'(q1.size() + q2.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
